// File: rtl/coffee_pkg.sv
// Shared types, codes and recipe table for the coffee maker recipe controller.
// Every block that needs state, stage or drink encodings imports this package.
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        STG_HEAT = 2'd0,
        STG_BREW = 2'd1,
        STG_MILK = 2'd2,
        STG_NONE = 2'd3
    } stage_e;

    localparam logic [1:0] DRINK_ESPRESSO  = 2'b00;
    localparam logic [1:0] DRINK_AMERICANO = 2'b01;
    localparam logic [1:0] DRINK_LATTE     = 2'b10;
    localparam logic [1:0] DRINK_INVALID   = 2'b11;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_WATER = 2'b01;
    localparam logic [1:0] FAULT_CUP   = 2'b10;
    localparam logic [1:0] FAULT_WDOG  = 2'b11;

    typedef struct packed {
        logic heater;
        logic pump;
        logic milk;
    } act_t;

    typedef struct packed {
        stage_e stage;
        logic   last;
    } recipe_step_t;

    // Stage list per drink; an out-of-range index reads as a terminal NONE step.
    function automatic recipe_step_t recipe_lookup(input logic [1:0] drink,
                                                   input logic [1:0] idx);
        recipe_step_t step;
        step.stage = STG_NONE;
        step.last  = 1'b1;
        case (drink)
            DRINK_ESPRESSO: begin
                case (idx)
                    2'd0:    step = '{stage: STG_HEAT, last: 1'b0};
                    2'd1:    step = '{stage: STG_BREW, last: 1'b1};
                    default: step = '{stage: STG_NONE, last: 1'b1};
                endcase
            end
            DRINK_AMERICANO: begin
                case (idx)
                    2'd0:    step = '{stage: STG_HEAT, last: 1'b0};
                    2'd1:    step = '{stage: STG_BREW, last: 1'b0};
                    2'd2:    step = '{stage: STG_BREW, last: 1'b1};
                    default: step = '{stage: STG_NONE, last: 1'b1};
                endcase
            end
            DRINK_LATTE: begin
                case (idx)
                    2'd0:    step = '{stage: STG_HEAT, last: 1'b0};
                    2'd1:    step = '{stage: STG_BREW, last: 1'b0};
                    2'd2:    step = '{stage: STG_MILK, last: 1'b1};
                    default: step = '{stage: STG_NONE, last: 1'b1};
                endcase
            end
            default: step = '{stage: STG_NONE, last: 1'b1};
        endcase
        return step;
    endfunction

endpackage

// File: rtl/sync2_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a rising-edge pulse
// taken from the synchronised copy (one clk wide).
module sync2_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments make the three flops shift as a chain; blocking would collapse them into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/brew_sequencer.sv
// Recipe controller: walks the per-drink stage list, drives the 1 Hz stage
// timer and the actuators, and supervises sensors and a cycle watchdog.
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter logic [1:0]  HEAT_T      = 2'd3,
    parameter logic [1:0]  BREW_T      = 2'd2,
    parameter logic [1:0]  MILK_T      = 2'd1,
    parameter logic [29:0] WDOG_CYCLES = 30'd600_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       cancel,
    input  logic [1:0] drink_sel,
    input  logic       cup_present,
    input  logic       water_ok,
    input  logic       fault_ack,
    output logic [1:0] tmr_value,
    output logic       tmr_start,
    input  logic       tmr_expired,
    output logic       heater_en,
    output logic       pump_en,
    output logic       milk_en,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] stage
);

    logic go;
    logic exp_s;
    logic unused_exp_rise;

    sync2_edge u_sync_start (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .d     (start_btn),
        .q     (),
        .rise  (go)
    );

    sync2_edge u_sync_expired (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .d     (tmr_expired),
        .q     (exp_s),
        .rise  (unused_exp_rise)
    );

    state_e       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [1:0]   drink_q, drink_d;
    logic         abort_q, abort_d;
    logic [29:0]  wdog_q, wdog_d;
    logic [1:0]   fault_code_q, fault_code_d;
    logic [1:0]   tmr_value_q, tmr_value_d;
    logic         tmr_start_q, tmr_start_d;
    act_t         act_q, act_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         fault_q, fault_d;
    stage_e       stage_q, stage_d;

    recipe_step_t cur_step;
    recipe_step_t nxt_step;
    logic         sensor_bad;
    logic [1:0]   sensor_code;
    logic         wdog_hit;
    logic         act_window;
    logic         abort_now;

    function automatic logic [1:0] stage_time(input stage_e s);
        case (s)
            STG_HEAT: return HEAT_T;
            STG_BREW: return BREW_T;
            STG_MILK: return MILK_T;
            default:  return 2'd0;
        endcase
    endfunction

    assign sensor_bad  = !cup_present || !water_ok;
    assign sensor_code = !water_ok ? FAULT_WATER : FAULT_CUP;
    assign cur_step    = recipe_lookup(drink_q, idx_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drink_d      = drink_q;
        abort_d      = abort_q;
        fault_code_d = fault_code_q;
        wdog_d       = (state_q == ST_RUN || state_q == ST_RELEASE) ? wdog_q + 30'd1 : 30'd0;
        wdog_hit     = (state_q == ST_RUN || state_q == ST_RELEASE) &&
                       (wdog_q == WDOG_CYCLES - 30'd1);

        case (state_q)
            ST_IDLE: begin
                if (go && !cancel && drink_sel != DRINK_INVALID) begin
                    if (sensor_bad) begin
                        state_d      = ST_FAULT;
                        fault_code_d = sensor_code;
                    end else begin
                        state_d = ST_ARM;
                        drink_d = drink_sel;
                        idx_d   = 2'd0;
                        abort_d = 1'b0;
                    end
                end
            end
            ST_ARM: begin
                if (sensor_bad) begin
                    state_d      = ST_FAULT;
                    fault_code_d = sensor_code;
                end else if (cancel) begin
                    state_d = ST_RELEASE;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sensor_bad) begin
                    state_d      = ST_FAULT;
                    fault_code_d = sensor_code;
                end else if (cancel) begin
                    state_d = ST_RELEASE;
                    abort_d = 1'b1;
                end else if (wdog_hit) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_WDOG;
                end else if (exp_s) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (sensor_bad) begin
                    state_d      = ST_FAULT;
                    fault_code_d = sensor_code;
                end else if (wdog_hit) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_WDOG;
                end else if (!exp_s) begin
                    if (abort_q) begin
                        state_d = ST_IDLE;
                    end else if (cur_step.last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARM;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAULT: begin
                if (fault_ack && !exp_s) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FAULT_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    assign nxt_step   = recipe_lookup(drink_d, idx_d);
    assign act_window = (state_d == ST_ARM) || (state_d == ST_RUN);

    always_comb begin
        act_d        = '0;
        act_d.heater = act_window && (nxt_step.stage == STG_HEAT);
        act_d.pump   = act_window && (nxt_step.stage == STG_BREW);
        act_d.milk   = act_window && (nxt_step.stage == STG_MILK);
        tmr_start_d  = act_window;
        tmr_value_d  = act_window ? stage_time(nxt_step.stage) : 2'd0;
        busy_d       = (state_d == ST_ARM) || (state_d == ST_RUN) ||
                       (state_d == ST_RELEASE) || (state_d == ST_DONE);
        done_d       = (state_d == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
        stage_d      = (state_d == ST_ARM || state_d == ST_RUN || state_d == ST_RELEASE)
                       ? nxt_step.stage : STG_NONE;
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            drink_q      <= DRINK_ESPRESSO;
            abort_q      <= 1'b0;
            wdog_q       <= 30'd0;
            fault_code_q <= FAULT_NONE;
            tmr_value_q  <= 2'd0;
            tmr_start_q  <= 1'b0;
            act_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            stage_q      <= STG_NONE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drink_q      <= drink_d;
            abort_q      <= abort_d;
            wdog_q       <= wdog_d;
            fault_code_q <= fault_code_d;
            tmr_value_q  <= tmr_value_d;
            tmr_start_q  <= tmr_start_d;
            act_q        <= act_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            stage_q      <= stage_d;
        end
    end

    // An abort cuts the actuators and timer in the cycle it is requested, not one later.
    assign abort_now  = cancel && (state_q == ST_ARM || state_q == ST_RUN);

    assign heater_en  = act_q.heater & ~abort_now;
    assign pump_en    = act_q.pump   & ~abort_now;
    assign milk_en    = act_q.milk   & ~abort_now;
    assign tmr_start  = tmr_start_q  & ~abort_now;
    assign tmr_value  = tmr_value_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign stage      = stage_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Self-checking bench for brew_sequencer: behavioural fast timer (1 tick = 50 clk),
// a stimulus table, a recipe-level reference model for random drinks, and corner sequences.
module tb_brew_sequencer;

    localparam int TICK = 50;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       start_btn;
    logic       cancel;
    logic [1:0] drink_sel;
    logic       cup_present;
    logic       water_ok;
    logic       fault_ack;
    logic       tmr_expired;
    logic [1:0] tmr_value;
    logic       tmr_start;
    logic       heater_en;
    logic       pump_en;
    logic       milk_en;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] stage;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    brew_sequencer #(
        .HEAT_T      (2'd3),
        .BREW_T      (2'd2),
        .MILK_T      (2'd1),
        .WDOG_CYCLES (30'd500)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .cancel      (cancel),
        .drink_sel   (drink_sel),
        .cup_present (cup_present),
        .water_ok    (water_ok),
        .fault_ack   (fault_ack),
        .tmr_value   (tmr_value),
        .tmr_start   (tmr_start),
        .tmr_expired (tmr_expired),
        .heater_en   (heater_en),
        .pump_en     (pump_en),
        .milk_en     (milk_en),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code),
        .stage       (stage)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Behavioural 1 Hz timer: counts ticks while started, flags expiry, clears only on a later tick.
    bit stuck = 1'b0;
    int div = 0;
    int ticks = 0;

    function automatic int tick_len(input logic [1:0] v);
        return (v == 2'd0) ? 4 : int'(v);
    endfunction

    always @(negedge clk_100MHz) begin
        if (!rst_n) begin
            div = 0; ticks = 0; tmr_expired = 1'b0;
        end else if (tmr_start && !tmr_expired) begin
            div++;
            if (div == TICK) begin
                div = 0;
                ticks++;
                if (!stuck && ticks == tick_len(tmr_value)) tmr_expired = 1'b1;
            end
        end else if (!tmr_start && tmr_expired) begin
            div++;
            if (div == TICK) begin
                div = 0; ticks = 0; tmr_expired = 1'b0;
            end
        end else if (!tmr_start) begin
            div = 0; ticks = 0;
        end
    end

    // Observation: one record {stage, tmr_value, milk, pump, heater} per timer start.
    bit         mon_en = 1'b0;
    logic [6:0] obs[$];
    logic [1:0] stage_seq[$];
    int         done_cnt, heat_cyc, pump_cyc, milk_cyc, inv_bad;
    logic [1:0] fault_seen;
    logic       busy_at_done, busy_after_done;
    logic       prev_start = 1'b0, prev_done = 1'b0;
    logic [1:0] prev_stage = 2'd3;

    always begin
        @(posedge clk_100MHz);
        #2;
        if (mon_en) begin
            if (tmr_start && !prev_start) begin
                obs.push_back({stage, tmr_value, milk_en, pump_en, heater_en});
                if (tmr_expired) inv_bad++;
            end
            if (stage != prev_stage) stage_seq.push_back(stage);
            if (heater_en) heat_cyc++;
            if (pump_en) pump_cyc++;
            if (milk_en) milk_cyc++;
            if (int'(heater_en) + int'(pump_en) + int'(milk_en) > 1) inv_bad++;
            if ((heater_en || pump_en || milk_en) && (!tmr_start || !busy)) inv_bad++;
            if (done) begin done_cnt++; busy_at_done = busy; end
            if (prev_done) busy_after_done = busy;
            if (fault) fault_seen = fault_code;
        end
        prev_start = tmr_start;
        prev_stage = stage;
        prev_done  = done;
    end

    task automatic clear_mon();
        obs.delete();
        stage_seq.delete();
        done_cnt = 0; heat_cyc = 0; pump_cyc = 0; milk_cyc = 0; inv_bad = 0;
        fault_seen = 2'd0; busy_at_done = 1'b0; busy_after_done = 1'b1;
    endtask

    function automatic logic [6:0] obs_at(input int i);
        if (i < obs.size()) return obs[i];
        return 7'h7f;
    endfunction

    task automatic press_go(input logic [1:0] d);
        @(negedge clk_100MHz);
        drink_sel = d;
        start_btn = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        start_btn = 1'b0;
    endtask

    task automatic wait_high(input string name, ref logic sig, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100MHz);
            if (sig) begin seen = 1'b1; break; end
        end
        check(name, seen, 1'b1);
    endtask

    // One full transaction; acknowledges any fault and returns with the DUT idle.
    task automatic run_txn(input logic [1:0] d, input bit cup, input bit water, input bit cxl);
        bit to = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk_100MHz);
        drink_sel = d; cup_present = cup; water_ok = water; cancel = cxl; start_btn = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        start_btn = 1'b0; cancel = 1'b0;
        drink_sel = 2'($urandom);
        repeat (5) @(negedge clk_100MHz);
        for (int i = 0; i < 3000; i++) begin
            if (fault) fault_ack = 1'b1;
            if (!busy && !fault) begin to = 1'b0; break; end
            @(negedge clk_100MHz);
        end
        fault_ack = 1'b0; cup_present = 1'b1; water_ok = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        mon_en = 1'b0;
        check("txn_complete", to, 1'b0);
        check("txn_fault_code_cleared", fault_code, 2'd0);
    endtask

    // Reference model: what a go with these inputs should produce, from the recipe rules alone.
    task automatic ref_model(input logic [1:0] d, input bit cup, input bit water, input bit cxl,
                             output int n, output int nd, output logic [1:0] f,
                             output logic [20:0] exp_list);
        logic [1:0] seq[3];
        logic [1:0] tv;
        int len;
        n = 0; nd = 0; f = 2'd0; exp_list = '1;
        len = 0;
        if (cxl || d == 2'b11) return;
        if (!water) begin f = 2'b01; return; end
        if (!cup) begin f = 2'b10; return; end
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = (d == 2'b10) ? 2'd2 : 2'd1;
        len = (d == 2'b00) ? 2 : 3;
        for (int i = 0; i < len; i++) begin
            tv = (seq[i] == 2'd0) ? 2'd3 : (seq[i] == 2'd1) ? 2'd2 : 2'd1;
            exp_list[7*i +: 7] = {seq[i], tv, 3'b001 << seq[i]};
        end
        n = len; nd = 1;
    endtask

    typedef struct {
        logic [1:0] drink;
        bit         cup;
        bit         water;
        bit         cxl;
        int         n_stages;
        int         n_done;
        logic [1:0] fcode;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [20:0] exp_list;
        logic [1:0]  ef;
        logic [7:0]  seq_pack;
        int          en, ed, cnt;
        logic [1:0]  rd;
        bit          rc, rw, rx;

        vecs[0] = '{2'b00, 1, 1, 0, 2, 1, 2'd0};
        vecs[1] = '{2'b01, 1, 1, 0, 3, 1, 2'd0};
        vecs[2] = '{2'b10, 1, 1, 0, 3, 1, 2'd0};
        vecs[3] = '{2'b11, 1, 1, 0, 0, 0, 2'd0};
        vecs[4] = '{2'b00, 0, 1, 0, 0, 0, 2'd2};
        vecs[5] = '{2'b01, 1, 0, 0, 0, 0, 2'd1};
        vecs[6] = '{2'b10, 0, 0, 0, 0, 0, 2'd1};
        vecs[7] = '{2'b10, 1, 1, 1, 0, 0, 2'd0};
        vecs[8] = '{2'b11, 0, 1, 0, 0, 0, 2'd0};

        rst_n = 1'b0; start_btn = 1'b0; cancel = 1'b0; drink_sel = 2'b00;
        cup_present = 1'b1; water_ok = 1'b1; fault_ack = 1'b0;
        #22;
        check("reset_outputs", {tmr_value, tmr_start, heater_en, pump_en, milk_en,
                                busy, done, fault, fault_code}, 0);
        check("reset_stage", stage, 2'd3);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_100MHz);

        for (int v = 0; v < 9; v++) begin
            run_txn(vecs[v].drink, vecs[v].cup, vecs[v].water, vecs[v].cxl);
            check($sformatf("vec%0d_stages", v), obs.size(), vecs[v].n_stages);
            check($sformatf("vec%0d_done", v), done_cnt, vecs[v].n_done);
            check($sformatf("vec%0d_fault", v), fault_seen, vecs[v].fcode);
        end

        // Espresso with default timings.
        run_txn(2'b00, 1, 1, 0);
        check("esp_heat_rec", obs_at(0), {2'd0, 2'd3, 3'b001});
        check("esp_brew_rec", obs_at(1), {2'd1, 2'd2, 3'b010});
        check_range("esp_heat_cycles", heat_cyc, 145, 160);
        check_range("esp_pump_cycles", pump_cyc, 95, 110);
        check("esp_done_pulses", done_cnt, 1);
        check("esp_busy_at_done", busy_at_done, 1'b1);
        check("esp_busy_after_done", busy_after_done, 1'b0);
        check("esp_invariants", inv_bad, 0);

        // Latte: stage sequence and milk stage.
        run_txn(2'b10, 1, 1, 0);
        seq_pack = '0;
        for (int i = 0; i < stage_seq.size() && i < 4; i++) seq_pack = {seq_pack[5:0], stage_seq[i]};
        check("latte_stage_count", stage_seq.size(), 4);
        check("latte_stage_seq", seq_pack, 8'h1B);
        check("latte_milk_rec", obs_at(2), {2'd2, 2'd1, 3'b100});
        check("latte_milk_cycles_nonzero", milk_cyc > 0, 1'b1);
        check("latte_invariants", inv_bad, 0);

        // Cancel 20 clk into the brew stage.
        clear_mon();
        mon_en = 1'b1;
        press_go(2'b00);
        wait_high("cxl_pump_started", pump_en, 1000);
        repeat (20) @(negedge clk_100MHz);
        cancel = 1'b1;
        #1;
        check("cxl_pump_same_cycle", pump_en, 1'b0);
        check("cxl_tmr_start_same_cycle", tmr_start, 1'b0);
        @(negedge clk_100MHz);
        cancel = 1'b0;
        cnt = 0;
        while (busy && cnt < 300) begin @(negedge clk_100MHz); cnt++; end
        check("cxl_back_to_idle", busy, 1'b0);
        check("cxl_expiry_clear_at_idle", tmr_expired, 1'b0);
        repeat (100) @(negedge clk_100MHz);
        mon_en = 1'b0;
        check("cxl_no_done", done_cnt, 0);
        check("cxl_stage_none", stage, 2'd3);

        // Cup removed just as the heat stage expires: fault holds until expiry clears.
        press_go(2'b00);
        wait_high("cup_heat_expired", tmr_expired, 1000);
        cup_present = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        check("cup_fault", fault, 1'b1);
        check("cup_fault_code", fault_code, 2'b10);
        check("cup_heater_off", heater_en, 1'b0);
        cup_present = 1'b1;
        fault_ack = 1'b1;
        repeat (10) @(negedge clk_100MHz);
        check("cup_fault_held_while_expired", fault, 1'b1);
        cnt = 0;
        while (tmr_expired && cnt < 300) begin @(negedge clk_100MHz); cnt++; end
        repeat (5) @(negedge clk_100MHz);
        check("cup_fault_released", fault, 1'b0);
        check("cup_code_cleared", fault_code, 2'b00);
        fault_ack = 1'b0;
        repeat (5) @(negedge clk_100MHz);

        // Timer never expires: watchdog fault, go ignored while faulted.
        stuck = 1'b1;
        press_go(2'b00);
        wait_high("wdog_armed", heater_en, 100);
        cnt = 0;
        while (!fault && cnt < 800) begin @(negedge clk_100MHz); cnt++; end
        check_range("wdog_latency", cnt, 499, 503);
        check("wdog_code", fault_code, 2'b11);
        check("wdog_heater_off", heater_en, 1'b0);
        press_go(2'b01);
        repeat (6) @(negedge clk_100MHz);
        check("wdog_go_ignored_fault", fault, 1'b1);
        check("wdog_go_ignored_busy", busy, 1'b0);
        stuck = 1'b0;
        fault_ack = 1'b1;
        repeat (4) @(negedge clk_100MHz);
        check("wdog_ack_idle", fault, 1'b0);
        check("wdog_ack_code", fault_code, 2'b00);
        fault_ack = 1'b0;
        repeat (5) @(negedge clk_100MHz);

        // Randomised drinks against the recipe model.
        for (int t = 0; t < 16; t++) begin
            rd = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 5) != 0);
            rw = ($urandom_range(0, 5) != 0);
            rx = ($urandom_range(0, 7) == 0);
            ref_model(rd, rc, rw, rx, en, ed, ef, exp_list);
            run_txn(rd, rc, rw, rx);
            check($sformatf("rnd%0d_d%0d_stages", t, rd), obs.size(), en);
            for (int i = 0; i < en; i++)
                check($sformatf("rnd%0d_rec%0d", t, i), obs_at(i), exp_list[7*i +: 7]);
            check($sformatf("rnd%0d_done", t), done_cnt, ed);
            check($sformatf("rnd%0d_fault", t), fault_seen, ef);
            check($sformatf("rnd%0d_invariants", t), inv_bad, 0);
        end

        // Asynchronous reset in the middle of RUN.
        press_go(2'b10);
        wait_high("rst_run_reached", heater_en, 100);
        repeat (20) @(negedge clk_100MHz);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {tmr_value, tmr_start, heater_en, pump_en, milk_en,
                                 busy, done, fault, fault_code}, 0);
        check("midrst_stage", stage, 2'd3);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        check("midrst_no_state_kept", {busy, tmr_start, heater_en}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
